// File: rtl/pipeline_defs.sv
// pipeline_defs: register-address width and EX operand mux select codes
package pipeline_defs;
    localparam int NB_REG = 5;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
endpackage

// File: rtl/fwd_sel_logic.sv
// fwd_sel_logic: priority forwarding select for one operand, youngest producer first
module fwd_sel_logic #(
    parameter int NB_REG = pipeline_defs::NB_REG
) (
    input  logic [NB_REG-1:0] src,
    input  logic              used,
    input  logic [NB_REG-1:0] ex_rd,
    input  logic              ex_we,
    input  logic [NB_REG-1:0] mem_rd,
    input  logic              mem_we,
    output logic [1:0]        sel
);
    import pipeline_defs::*;
    always_comb begin
        sel = (!used || src == '0)          ? FWD_RF  :
              (ex_we && ex_rd == src)       ? FWD_MEM :
              (mem_we && mem_rd == src)     ? FWD_WB  : FWD_RF;
    end
endmodule

// File: rtl/forwarding_unit.sv
// forwarding_unit: registered EX operand forwarding selects and load-use stall request
module forwarding_unit #(
    parameter int NB_REG = pipeline_defs::NB_REG
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_halt,
    input  logic              i_flush,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    input  logic              i_id_use_rs,
    input  logic              i_id_use_rt,
    input  logic [NB_REG-1:0] i_id_rd,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_read,
    output logic [1:0]        o_fwd_a_sel,
    output logic [1:0]        o_fwd_b_sel,
    output logic              o_load_use
);
    import pipeline_defs::*;
    logic [NB_REG-1:0] ex_rd, mem_rd;
    logic              ex_we, ex_ld, mem_we;
    logic [1:0]        sel_a, sel_b;
    logic              bubble;
    fwd_sel_logic #(.NB_REG(NB_REG)) u_sel_a (
        .src(i_id_rs), .used(i_id_use_rs),
        .ex_rd(ex_rd), .ex_we(ex_we), .mem_rd(mem_rd), .mem_we(mem_we),
        .sel(sel_a)
    );
    fwd_sel_logic #(.NB_REG(NB_REG)) u_sel_b (
        .src(i_id_rt), .used(i_id_use_rt),
        .ex_rd(ex_rd), .ex_we(ex_we), .mem_rd(mem_rd), .mem_we(mem_we),
        .sel(sel_b)
    );
    always_comb begin
        o_load_use = i_rst_n && !i_halt && ex_ld && ex_we && ex_rd != '0 &&
                     ((i_id_use_rs && i_id_rs == ex_rd) || (i_id_use_rt && i_id_rt == ex_rd));
        bubble     = o_load_use || i_flush;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ex_rd       <= '0;
            ex_we       <= 1'b0;
            ex_ld       <= 1'b0;
            mem_rd      <= '0;
            mem_we      <= 1'b0;
            o_fwd_a_sel <= FWD_RF;
            o_fwd_b_sel <= FWD_RF;
        end else if (!i_halt) begin
            mem_rd      <= ex_rd;
            mem_we      <= ex_we;
            ex_rd       <= bubble ? '0   : i_id_rd;
            ex_we       <= bubble ? 1'b0 : i_id_reg_write;
            ex_ld       <= bubble ? 1'b0 : i_id_mem_read;
            o_fwd_a_sel <= bubble ? FWD_RF : sel_a;
            o_fwd_b_sel <= bubble ? FWD_RF : sel_b;
        end
    end
endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: directed vector table plus halt/reset sequences for forwarding_unit
module tb_forwarding_unit;
    typedef struct {
        logic       flush;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] rd;
        logic       we, ld;
        logic       e_lu;
        logic [1:0] e_a, e_b;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst_n, halt, flush, use_rs, use_rt, reg_write, mem_read;
    logic [4:0] rs, rt, rd;
    logic [1:0] a_sel, b_sel;
    logic       load_use;
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[20];
    always #5 clk = ~clk;
    forwarding_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt), .i_flush(flush),
        .i_id_rs(rs), .i_id_rt(rt), .i_id_use_rs(use_rs), .i_id_use_rt(use_rt),
        .i_id_rd(rd), .i_id_reg_write(reg_write), .i_id_mem_read(mem_read),
        .o_fwd_a_sel(a_sel), .o_fwd_b_sel(b_sel), .o_load_use(load_use)
    );
    task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask
    function automatic vec_t mk(input logic fl, input int s, input int t, input logic us, input logic ut,
                                input int d, input logic w, input logic l,
                                input logic lu, input logic [1:0] ea, input logic [1:0] eb);
        vec_t v;
        v.flush = fl; v.rs = 5'(s); v.rt = 5'(t); v.urs = us; v.urt = ut;
        v.rd = 5'(d); v.we = w; v.ld = l; v.e_lu = lu; v.e_a = ea; v.e_b = eb;
        return v;
    endfunction
    task automatic drive(input vec_t v);
        flush = v.flush; rs = v.rs; rt = v.rt; use_rs = v.urs; use_rt = v.urt;
        rd = v.rd; reg_write = v.we; mem_read = v.ld;
    endtask
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1 chk("load_use", idx, {1'b0, load_use}, {1'b0, v.e_lu});
        @(posedge clk);
        #1;
        chk("fwd_a", idx, a_sel, v.e_a);
        chk("fwd_b", idx, b_sel, v.e_b);
    endtask
    initial begin
        vec_t nop, v;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        //            fl rs rt urs urt rd we ld  lu  a      b
        tbl[0]  = mk(0, 1, 2, 1, 1, 3, 1, 0, 0, 2'b00, 2'b00); // add $3,$1,$2
        tbl[1]  = mk(0, 3, 5, 1, 1, 4, 1, 0, 0, 2'b01, 2'b00); // sub $4,$3,$5
        tbl[2]  = mk(0, 1, 2, 1, 1, 3, 1, 0, 0, 2'b00, 2'b00); // add $3,$1,$2
        tbl[3]  = nop;
        tbl[4]  = mk(0, 7, 3, 1, 1, 6, 1, 0, 0, 2'b00, 2'b10); // or $6,$7,$3
        tbl[5]  = mk(0, 1, 2, 1, 1, 3, 1, 0, 0, 2'b00, 2'b00); // add $3,$1,$2
        tbl[6]  = mk(0, 9, 3, 1, 0, 3, 1, 0, 0, 2'b00, 2'b00); // addi $3,$9
        tbl[7]  = mk(0, 3, 3, 1, 1, 8, 1, 0, 0, 2'b01, 2'b01); // and $8,$3,$3
        tbl[8]  = mk(0, 1, 2, 1, 0, 2, 1, 1, 0, 2'b00, 2'b00); // lw $2,0($1)
        tbl[9]  = mk(0, 2, 2, 1, 1, 4, 1, 0, 1, 2'b00, 2'b00); // add $4,$2,$2 stalls
        tbl[10] = mk(0, 2, 2, 1, 1, 4, 1, 0, 0, 2'b10, 2'b10); // add re-issued
        tbl[11] = mk(0, 1, 0, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00); // lw $0,0($1)
        tbl[12] = mk(0, 0, 0, 1, 1, 5, 1, 0, 0, 2'b00, 2'b00); // consumer of $0
        tbl[13] = mk(0, 10, 5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00); // unused rt matches
        tbl[14] = mk(0, 1, 0, 1, 0, 7, 1, 1, 0, 2'b00, 2'b00); // lw $7,0($1)
        tbl[15] = mk(1, 7, 7, 1, 1, 9, 1, 0, 1, 2'b00, 2'b00); // flush + load-use
        tbl[16] = mk(0, 7, 1, 1, 1, 11, 1, 0, 0, 2'b10, 2'b00); // add $11,$7,$1
        tbl[17] = mk(1, 11, 11, 1, 1, 12, 1, 0, 0, 2'b00, 2'b00); // flushed sub
        tbl[18] = mk(0, 11, 0, 1, 1, 13, 1, 0, 0, 2'b10, 2'b00); // add $13,$11,$0
        tbl[19] = mk(0, 13, 4, 1, 1, 14, 1, 1, 0, 2'b01, 2'b00); // lw $14,0($13)
        rst_n = 1'b0; halt = 1'b0;
        drive(nop);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", -1, a_sel, 2'b00);
        chk("reset_b", -1, b_sel, 2'b00);
        chk("reset_lu", -1, {1'b0, load_use}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(tbl[i], i);
        // freeze with the load in EX and a dependent add in ID
        v = mk(0, 14, 13, 1, 1, 15, 1, 0, 1, 2'b00, 2'b00);
        @(negedge clk);
        drive(v);
        halt = 1'b1;
        #1 chk("halt_lu_masked", 100, {1'b0, load_use}, 2'b00);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("halt_a", 101, a_sel, 2'b01);
            chk("halt_b", 101, b_sel, 2'b00);
        end
        @(negedge clk);
        halt = 1'b0;
        #1 chk("resume_lu", 102, {1'b0, load_use}, 2'b01);
        rst_n = 1'b0;
        #1 chk("reset_lu_masked", 103, {1'b0, load_use}, 2'b00);
        @(posedge clk);
        #1;
        chk("midstall_reset_a", 104, a_sel, 2'b00);
        chk("midstall_reset_b", 104, b_sel, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("after_reset_lu", 105, {1'b0, load_use}, 2'b00);
        v = mk(0, 13, 14, 1, 1, 16, 1, 0, 0, 2'b00, 2'b00);
        step(v, 106);
        v = mk(0, 16, 14, 1, 1, 17, 1, 0, 0, 2'b01, 2'b00);
        step(v, 107);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/forwarding_unit.md
# forwarding_unit

Registered forwarding and load-use hazard controller for the 5-stage MIPS pipeline. It tracks destination-register information for the instructions in EX and MEM in its own shift-register scoreboard. From that it produces the 2-bit select codes that drive the EX-stage operand `mux4to1` instances for operands A and B. It also raises a load-use stall request toward the PC/IF-ID registers. It sits between the ID/EX boundary and the EX operand multiplexers.

## Interface
- `NB_REG`, 5 — register-address width
- `i_clk` in 1 — pipeline clock
- `i_rst_n` in 1 — synchronous, active-low reset
- `i_halt` in 1 — debug-unit freeze; all state holds, outputs hold
- `i_flush` in 1 — control-hazard flush; the ID instruction becomes a bubble entering EX
- `i_id_rs` in NB_REG — rs of the instruction in ID
- `i_id_rt` in NB_REG — rt of the instruction in ID
- `i_id_use_rs` in 1 — the ID instruction reads rs
- `i_id_use_rt` in 1 — the ID instruction reads rt
- `i_id_rd` in NB_REG — final destination of the ID instruction (post RegDst)
- `i_id_reg_write` in 1 — the ID instruction writes the register file
- `i_id_mem_read` in 1 — the ID instruction is a load
- `o_fwd_a_sel` out 2 — operand-A mux select, valid during EX
- `o_fwd_b_sel` out 2 — operand-B mux select, valid during EX
- `o_load_use` out 1 — stall request: hold PC and IF/ID, insert a bubble into EX

## Operation
- Select encoding:
  - 00: register-file value
  - 01: EX/MEM ALU result
  - 10: MEM/WB writeback value
  - 11: reserved and never produced
- Scoreboard registers:
  - EX slot: `ex_rd`, `ex_we`, `ex_ld`
  - MEM slot: `mem_rd`, `mem_we`
- Slot semantics: each slot describes the instruction that occupies that stage during the current cycle.
- Advance (every edge with `i_rst_n`=1 and `i_halt`=0), in this order of cases:
  - Shift: MEM slot ← EX slot.
  - Normal load: if `o_load_use`=0 and `i_flush`=0, EX slot ← ID inputs.
  - Bubble: otherwise, EX slot ← bubble (`we`=0, `ld`=0, `rd`=0).
- Select computation for operand A, done at the advance edge and registered:
  - Forced 00 when the EX slot is loaded with a bubble.
  - Forced 00 when `i_id_use_rs`=0 or `i_id_rs`=0.
  - 01 if `ex_we` && `ex_rd`==`i_id_rs`.
  - Else 10 if `mem_we` && `mem_rd`==`i_id_rs`.
  - Else 00.
  - Priority is 01 over 10, so the youngest producer wins.
- Operand B: identical, using rt and `i_id_use_rt`.
- Register 0 is never forwarded, even if a producer names rd=0.
- Load-use hazard, combinational from the scoreboard and ID inputs:
  - `o_load_use` = `ex_ld` && `ex_we` && `ex_rd`≠0 && ((`i_id_use_rs` && `i_id_rs`==`ex_rd`) || (`i_id_use_rt` && `i_id_rt`==`ex_rd`)).
  - Masked to 0 while `i_halt`=1 or `i_rst_n`=0.
- After a one-cycle load-use bubble, the load sits in MEM and the dependent instruction is re-evaluated; it receives 10.
- Simultaneous `i_flush` and `o_load_use`: the flush wins. Bubble inserted, no extra stall cycle; the stall output is still asserted that cycle and the PC logic gives flush priority.
- No write-before-read: the register file is write-first, so a WB-stage producer needs no forwarding.

## Timing
- Reset (sync, `i_rst_n`=0 at an edge):
  - All scoreboard fields are 0.
  - `o_fwd_a_sel` and `o_fwd_b_sel` are 00.
  - `o_load_use` is 0.
- Select latency: computed from ID-cycle inputs, registered at the ID→EX edge, stable for the entire EX cycle of the consumer.
- `o_load_use`: same-cycle combinational, valid during the ID cycle of the consumer.
- Stall length: exactly one cycle per load-use pair.
- `i_halt`=1: zero state change, registered outputs hold; resuming continues exactly where the pipeline froze.
- Reset asserted mid-stall: the stall clears on the next edge and the scoreboard empties.

## Structure
- Shared package/header `pipeline_defs`:
  - `NB_REG`
  - Select localparams `FWD_RF`=2'b00, `FWD_MEM`=2'b01, `FWD_WB`=2'b10
  - These are used by both this block and the datapath mux wiring.
- One natural sub-module, `fwd_sel_logic`:
  - Combinational priority comparator for a single operand.
  - Inputs: src, use, ex/mem rd/we.
  - Output: 2-bit select.
  - Instantiated twice, for A and B.

## Test plan
- Back-to-back ALU dependency:
  - Stimulus: `add $3,$1,$2` then `sub $4,$3,$5`.
  - Required: `o_fwd_a_sel`=01 and `o_fwd_b_sel`=00 during the sub's EX cycle.
- Distance-2 dependency:
  - Stimulus: `add $3` / `nop` / `or $6,$7,$3`.
  - Required: `o_fwd_b_sel`=10.
- Double producer:
  - Stimulus: `add $3` / `addi $3` / `and $8,$3,$3`.
  - Required: both selects=01, youngest producer wins.
- Load-use:
  - Stimulus: `lw $2,0($1)` then `add $4,$2,$2`.
  - Required: `o_load_use`=1 for exactly one cycle; the bubble enters EX; then add EX selects A=B=10.
- $zero and unused operand:
  - Stimulus: producer with rd=0 followed by a consumer of rs=0; also `i_id_use_rt`=0 with a matching rt.
  - Required: selects stay 00 and `o_load_use`=0.
- Halt and reset:
  - Stimulus: assert `i_halt` during a pending forward; then drop `i_rst_n` mid load-use stall.
  - Required: outputs frozen while halted; after the reset edge, all outputs are 00/0.
